// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the fetch/PC logic.
package imem_loader_pkg;

  // Loader control states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam int BYTES_PER_WORD = 4;

  // The PC logic uses these same values, so load addresses line up with fetches.
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd4;
  localparam logic [31:0] DEFAULT_STRIDE    = 32'd4;

  // States in which a stream byte may be taken.
  function automatic logic state_accepts(state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA);
  endfunction

  // States that count as a load in progress.
  function automatic logic state_busy(state_e s);
    return state_accepts(s) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in and instruction-memory write bus out of the loader.
interface imem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  // Master: the byte source, which also observes the memory writes.
  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  // Slave: the loader itself.
  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_word_packer.sv
// Packs bytes MSB-first into a 32-bit word. word_full is high in the cycle
// whose shift completes the word, so the caller can leave its data state on
// the same edge as the fourth byte.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_full
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;

  // Shift register and byte index; clr drops any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (clr) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (shift_en) begin
      word_q <= {word_q[23:0], in_data};
      idx_q  <= idx_q + 2'd1;
    end
  end

  assign word      = word_q;
  assign word_full = shift_en && (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Receives a length-prefixed byte stream, packs it into instruction words and
// writes them at PC-matching addresses; keeps the CPU in reset until done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter logic [31:0] STRIDE    = DEFAULT_STRIDE,
  parameter int          MAX_WORDS = 7,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  imem_loader_if.slave     bus,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] words_written
);

  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_WORDS);

  state_e           state_q, state_d;
  logic [7:0]       len_hi_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] words_q;
  logic [31:0]      addr_q;
  logic             in_ready_q, busy_q, cpu_hold_q, done_q, err_q, wr_en_q;

  logic             accept;
  logic [CNT_W-1:0] len_rx;
  logic             start_ok;
  logic             pk_clr, pk_shift, pk_full;
  logic [31:0]      pk_word;

  assign accept   = bus.in_valid && in_ready_q;
  assign len_rx   = CNT_W'({len_hi_q, bus.in_data});
  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign pk_clr   = (state_q == ST_LEN_LO) && accept;
  assign pk_shift = (state_q == ST_DATA) && accept;

  imem_word_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (pk_clr),
    .shift_en (pk_shift),
    .in_data  (bus.in_data),
    .word     (pk_word),
    .word_full(pk_full)
  );

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_LEN_HI;
      ST_LEN_HI:        if (accept) state_d = ST_LEN_LO;
      ST_LEN_LO: begin
        if (accept) begin
          if (len_rx == '0 || len_rx > MAX_N) state_d = ST_DONE;
          else                                state_d = ST_DATA;
        end
      end
      ST_DATA:          if (pk_full) state_d = ST_WRITE;
      ST_WRITE:         state_d = (words_q + CNT_W'(1) == len_q) ? ST_DONE : ST_DATA;
      default:          state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs, all decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_hi_q   <= '0;
      len_q      <= '0;
      words_q    <= '0;
      addr_q     <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= state_accepts(state_d);
      busy_q     <= state_busy(state_d);
      cpu_hold_q <= (state_d != ST_DONE);
      done_q     <= (state_d == ST_DONE);
      wr_en_q    <= (state_d == ST_WRITE);
      if (start_ok) begin
        err_q   <= 1'b0;
        words_q <= '0;
      end
      if (state_q == ST_LEN_HI && accept) len_hi_q <= bus.in_data;
      if (state_q == ST_LEN_LO && accept) begin
        len_q  <= len_rx;
        addr_q <= BASE_ADDR;
        if (len_rx > MAX_N) err_q <= 1'b1;
      end
      if (state_q == ST_WRITE) begin
        addr_q  <= addr_q + STRIDE;
        words_q <= words_q + CNT_W'(1);
      end
    end
  end

  // Address and data are forced to zero outside the write strobe.
  assign bus.in_ready  = in_ready_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_en_q ? addr_q : '0;
  assign bus.wr_data   = wr_en_q ? pk_word : '0;
  assign cpu_hold      = cpu_hold_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as words are
// driven and compared as the write strobe appears.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cpu_hold, busy, done, err;
  logic [15:0] words_written;

  imem_loader_if bus();

  imem_loader #(
    .BASE_ADDR(32'd4), .STRIDE(32'd4), .MAX_WORDS(7), .CNT_W(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          wr_count = 0;
  int          ready_viol = 0;
  logic [31:0] last_addr = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write monitor and scoreboard pop; also flags in_ready low mid-load outside WRITE.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && !bus.in_ready && !bus.wr_en) ready_viol++;
      if (bus.wr_en) begin
        wr_count++;
        last_addr = bus.wr_addr;
        $display("wr addr=%h data=%h", bus.wr_addr, bus.wr_data);
        if (exp_q.size() == 0) begin
          check_eq("wr_unexpected", 32'd1, 32'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check_eq("wr_addr", bus.wr_addr, e.addr);
          check_eq("wr_data", bus.wr_data, e.data);
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one byte after 'gap' idle cycles; returns at the negedge after transfer.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_eq("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] a, input int maxgap);
    wr_t e;
    e.addr = a;
    e.data = w;
    exp_q.push_back(e);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], int'($urandom_range(0, maxgap)));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int w0;
    logic [31:0] w;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("test reset");
    check_eq("rst_cpu_hold", cpu_hold, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_in_ready", bus.in_ready, 0);
    check_eq("rst_words", words_written, 0);

    $display("test basic load");
    w0 = wr_count;
    pulse_start();
    check_eq("t1_busy", busy, 1);
    check_eq("t1_ready", bus.in_ready, 1);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'h0064_1020, 32'd4, 0);
    send_word(32'h0064_0822, 32'd8, 0);
    wait_done();
    check_eq("t1_done", done, 1);
    check_eq("t1_cpu_hold", cpu_hold, 0);
    check_eq("t1_busy_end", busy, 0);
    check_eq("t1_words", words_written, 2);
    check_eq("t1_wr_count", wr_count - w0, 2);
    check_eq("t1_pending", exp_q.size(), 0);

    $display("test zero length");
    w0 = wr_count;
    pulse_start();
    check_eq("t2_done_clr", done, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check_eq("t2_done", done, 1);
    check_eq("t2_err", err, 0);
    check_eq("t2_words", words_written, 0);
    check_eq("t2_wr_count", wr_count - w0, 0);

    $display("test oversize");
    w0 = wr_count;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h08, 0);
    check_eq("t3_err", err, 1);
    check_eq("t3_done", done, 1);
    bus.in_data  = 8'hAA;
    bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t3_ready", bus.in_ready, 0);
    check_eq("t3_done_hold", done, 1);
    bus.in_valid = 1'b0;
    check_eq("t3_wr_count", wr_count - w0, 0);

    $display("test stalls");
    w0 = wr_count;
    ready_viol = 0;
    pulse_start();
    check_eq("t4_err_clr", err, 0);
    send_byte(8'h00, 2);
    send_byte(8'h04, 1);
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      send_word(w, 32'd4 + 32'(i) * 32'd4, 3);
    end
    wait_done();
    check_eq("t4_words", words_written, 4);
    check_eq("t4_last_addr", last_addr, 32'd16);
    check_eq("t4_wr_count", wr_count - w0, 4);
    check_eq("t4_ready_drops", ready_viol, 0);

    $display("test reset mid-load");
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_word(32'h1111_2222, 32'd4, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_eq("t5_cpu_hold", cpu_hold, 1);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_wr_en", bus.wr_en, 0);
    check_eq("t5_words", words_written, 0);
    rst = 1'b0;
    @(negedge clk);
    w0 = wr_count;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(32'hDEAD_BEEF, 32'd4, 0);
    wait_done();
    check_eq("t5_wr_count", wr_count - w0, 1);
    check_eq("t5_words_end", words_written, 1);

    $display("test start handling");
    w0 = wr_count;
    check_eq("t6_done_before", done, 1);
    pulse_start();
    check_eq("t6_done_low", done, 0);
    check_eq("t6_cpu_hold", cpu_hold, 1);
    send_byte(8'h00, 0);
    pulse_start();
    check_eq("t6_busy_kept", busy, 1);
    send_byte(8'h01, 0);
    send_word(32'h8CC5_0000, 32'd4, 0);
    wait_done();
    check_eq("t6_done_after", done, 1);
    check_eq("t6_words", words_written, 1);
    check_eq("t6_wr_count", wr_count - w0, 1);
    check_eq("t6_pending", exp_q.size(), 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
